eth_phy_mgmt_sequencer: RTL and testbench
=========================================

Name: eth_phy_mgmt_sequencer

Overview:
- Owns the Ethernet PHY management path and drives the PHY reset pin.
- After reset it pulses the PHY reset, waits for PHY power-up, then issues a fixed init sequence through the MDIO master command/response streams: soft reset, poll for reset completion, advertise 10/100, restart autonegotiation.
- It then polls BMSR periodically and publishes the link status.
- Sits between the top level and the MDIO master; it replaces the hard-tied eth_rstn and the hand-fed constant MDIO command.

Parameters:
PHY_ADDR, 5'd1, MDIO PHY address used for every command
PHY_RESET_CYCLES, 1000, clocks phy_rstn is held low
POWERUP_CYCLES, 5_000_000, clocks between phy_rstn rising and the first command
POLL_CYCLES, 1_000_000, gap between link-status polls
RESP_TIMEOUT_CYCLES, 65536, maximum clocks to wait for accept, busy-low or read data
RESET_POLL_LIMIT, 16, maximum BMCR reads while waiting for the soft-reset bit to clear

Ports:
clk  in  1  system clock (udp_sys_clk domain)
reset_n  in  1  asynchronous, active-low reset
restart  in  1  single-cycle pulse; re-runs the whole sequence
phy_rstn  out  1  PHY hardware reset, active low
cmd_phy_addr  out  5  MDIO command PHY address (always PHY_ADDR)
cmd_reg_addr  out  5  MDIO register address
cmd_data  out  16  write data
cmd_opcode  out  2  2'b01 write, 2'b10 read
cmd_valid  out  1  command valid
cmd_ready  in  1  command accepted
data_out  in  16  read data
data_out_valid  in  1  read data valid
data_out_ready  out  1  read data accept
busy  in  1  MDIO master transaction in progress
init_done  out  1  init sequence completed
link_up  out  1  BMSR bit 2 from the second read of the latest poll
error  out  1  sticky fault flag
error_code  out  2  0 none, 1 TIMEOUT, 2 RESET_STUCK

Behaviour:
- Reset values: phy_rstn=0, cmd_valid=0, data_out_ready=0, init_done=0, link_up=0, error=0, error_code=0. cmd_* fields are 0.
- States: HOLD_RST → PWR_WAIT → W_BMCR_RST → R_BMCR → W_ANAR → W_BMCR_AN → POLL_GAP → R_BMSR1 → R_BMSR2 → POLL_GAP …; ERROR is terminal.
- HOLD_RST: phy_rstn=0 for PHY_RESET_CYCLES, then phy_rstn=1 (registered, stays 1 until restart) and go to PWR_WAIT.
- PWR_WAIT: POWERUP_CYCLES clocks.
- Each command state runs a common executor:
  - ISSUE: cmd_valid=1 with stable fields until cmd_ready (AXIS rules; never drop valid before accept).
  - Writes: after accept, wait busy==0, sampled no earlier than 2 clocks after accept.
  - Reads: data_out_ready=1 only while waiting; data is captured on the valid&&ready cycle.
  - The timeout counter restarts at entry to ISSUE and again at accept. Expiry → ERROR, error_code=TIMEOUT.
- Command sequence:
  - W_BMCR_RST: write reg 0x00 = 0x8000.
  - R_BMCR: read reg 0x00.
    - bit15==0 → W_ANAR.
    - bit15==1 → re-read immediately.
    - After RESET_POLL_LIMIT reads with bit15 still set → ERROR, RESET_STUCK.
  - W_ANAR: write reg 0x04 = 0x01E1.
  - W_BMCR_AN: write reg 0x00 = 0x1200; on completion init_done=1 (stays 1 until restart).
- POLL_GAP waits POLL_CYCLES. The first poll after init also waits.
- BMSR link bit is latched-low, so reg 0x01 is read twice back-to-back. The first result is discarded. link_up is updated from bit 2 of the second read, one clock after capture.
- ERROR: cmd_valid=0, data_out_ready=0, init_done=0, link_up=0, error=1. phy_rstn keeps its value. Only restart or reset_n exits.
- restart:
  - Latched as pending in any state.
  - If a handshake is outstanding (cmd_valid high or response pending), that transaction completes or times out first; a timeout during pending restart does not set error.
  - Then clear init_done, link_up, error and error_code, and go to HOLD_RST.
- restart coincident with the final ack of a transaction: the transaction counts, then restart is taken.
- Counters: a single 32-bit down-counter is shared. Parameters must be ≥1; a value of 1 means one clock.
- reset_n assertion mid-handshake: outputs are forced to reset values asynchronously. The MDIO master is reset in the same domain.

Decomposition:
- Package eth_phy_mgmt_pkg:
  - MDIO_OP_WRITE/MDIO_OP_READ
  - register addresses BMCR/BMSR/ANAR
  - BMCR_SOFT_RESET, ANAR_10_100_ALL, BMCR_AN_RESTART, BMSR_LINK_BIT
  - error_code_t enum
  - state_t enum
- One sub-module, mgmt_delay_timer: load value, start, expired pulse, async active-low reset. It serves the hold, power-up, poll and timeout delays.

Test Plan:
1. PHY_RESET_CYCLES=4, POWERUP_CYCLES=10, cmd_ready always 1 → phy_rstn rises 4 clocks after reset_n release; first cmd_valid 10 clocks later with phy=1, reg=0x00, data=0x8000, op=01.
2. BMCR reads return 0x8000, 0x8000, 0x1140 → exactly 3 reads; then writes 0x04=0x01E1 and 0x00=0x1200; init_done=1; error=0.
3. POLL_CYCLES=20; BMSR pair returns 0x7809, 0x782D → link_up=1. Next pair 0x782D, 0x7809 → link_up=0.
4. Model never asserts data_out_valid on the first BMCR read, RESP_TIMEOUT_CYCLES=50 → error=1, error_code=1 at timeout; cmd_valid stays 0 thereafter.
5. BMCR always returns 0x8000, RESET_POLL_LIMIT=16 → exactly 16 reads, then error_code=2, init_done=0.
6. restart pulsed while cmd_valid=1 and cmd_ready=0 for 5 clocks → cmd fields stable until accept; write completes; then phy_rstn=0 and the sequence reruns to init_done=1.

Source files
------------

// File: rtl/eth_phy_mgmt_pkg.sv
// Shared constants and types for the Ethernet PHY management sequencer:
// MDIO opcodes, clause-22 register map, init values and FSM encodings.
package eth_phy_mgmt_pkg;

  localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
  localparam logic [1:0] MDIO_OP_READ  = 2'b10;

  localparam logic [4:0] REG_BMCR = 5'h00;
  localparam logic [4:0] REG_BMSR = 5'h01;
  localparam logic [4:0] REG_ANAR = 5'h04;

  localparam logic [15:0] BMCR_SOFT_RESET = 16'h8000;
  localparam logic [15:0] ANAR_10_100_ALL = 16'h01E1;
  localparam logic [15:0] BMCR_AN_RESTART = 16'h1200;
  // Mask form so the whole read word is consumed when testing the bit.
  localparam logic [15:0] BMSR_LINK_BIT   = 16'h0004;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'd0,
    ERR_TIMEOUT     = 2'd1,
    ERR_RESET_STUCK = 2'd2
  } error_code_t;

  typedef enum logic [3:0] {
    ST_HOLD_RST,
    ST_PWR_WAIT,
    ST_W_BMCR_RST,
    ST_R_BMCR,
    ST_W_ANAR,
    ST_W_BMCR_AN,
    ST_POLL_GAP,
    ST_R_BMSR1,
    ST_R_BMSR2,
    ST_ERROR
  } state_t;

  // Phases of the common command executor.
  typedef enum logic [1:0] {
    EX_ISSUE,
    EX_WR_SETTLE,
    EX_WR_BUSY,
    EX_RD_WAIT
  } exec_t;

  typedef struct packed {
    logic        is_cmd;
    logic [4:0]  reg_addr;
    logic [15:0] data;
    logic [1:0]  opcode;
  } cmd_t;

  function automatic cmd_t cmd_for_state(state_t s);
    cmd_t c;
    c = '0;
    case (s)
      ST_W_BMCR_RST: c = '{1'b1, REG_BMCR, BMCR_SOFT_RESET, MDIO_OP_WRITE};
      ST_R_BMCR:     c = '{1'b1, REG_BMCR, 16'h0000,        MDIO_OP_READ};
      ST_W_ANAR:     c = '{1'b1, REG_ANAR, ANAR_10_100_ALL, MDIO_OP_WRITE};
      ST_W_BMCR_AN:  c = '{1'b1, REG_BMCR, BMCR_AN_RESTART, MDIO_OP_WRITE};
      ST_R_BMSR1:    c = '{1'b1, REG_BMSR, 16'h0000,        MDIO_OP_READ};
      ST_R_BMSR2:    c = '{1'b1, REG_BMSR, 16'h0000,        MDIO_OP_READ};
      default:       c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/eth_phy_mgmt_sequencer_timer.sv
// Shared 32-bit down-counter: a load of N makes expired pulse N clocks later.
// It comes out of reset already running with RST_VALUE so the first hold needs no start.
module mgmt_delay_timer #(
  parameter logic [31:0] RST_VALUE = 32'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] load_value,
  output logic        expired
);

  logic [31:0] count_q, count_d;
  logic        running_q, running_d;

  always_comb begin
    count_d   = count_q;
    running_d = running_q;
    expired   = running_q && (count_q <= 32'd1);
    if (start) begin
      count_d   = load_value;
      running_d = 1'b1;
    end else if (running_q) begin
      if (expired) begin
        running_d = 1'b0;
      end else begin
        count_d = count_q - 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= RST_VALUE;
      running_q <= 1'b1;
    end else begin
      count_q   <= count_d;
      running_q <= running_d;
    end
  end

endmodule

// File: rtl/eth_phy_mgmt_sequencer.sv
// PHY management sequencer: drives the PHY reset pin, runs the MDIO init
// sequence (soft reset, reset poll, ANAR, AN restart) and polls BMSR for link.
module eth_phy_mgmt_sequencer
  import eth_phy_mgmt_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR            = 5'd1,
  parameter int         PHY_RESET_CYCLES    = 1000,
  parameter int         POWERUP_CYCLES      = 5_000_000,
  parameter int         POLL_CYCLES         = 1_000_000,
  parameter int         RESP_TIMEOUT_CYCLES = 65536,
  parameter int         RESET_POLL_LIMIT    = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        restart,
  output logic        phy_rstn,
  output logic [4:0]  cmd_phy_addr,
  output logic [4:0]  cmd_reg_addr,
  output logic [15:0] cmd_data,
  output logic [1:0]  cmd_opcode,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  input  logic [15:0] data_out,
  input  logic        data_out_valid,
  output logic        data_out_ready,
  input  logic        busy,
  output logic        init_done,
  output logic        link_up,
  output logic        error,
  output logic [1:0]  error_code
);

  localparam logic [31:0] HOLD_LOAD  = 32'(PHY_RESET_CYCLES);
  localparam logic [31:0] PWR_LOAD   = 32'(POWERUP_CYCLES);
  localparam logic [31:0] POLL_LOAD  = 32'(POLL_CYCLES);
  localparam logic [31:0] TO_LOAD    = 32'(RESP_TIMEOUT_CYCLES);
  localparam logic [15:0] POLL_LIMIT = 16'(RESET_POLL_LIMIT);

  state_t      state_q, state_d;
  exec_t       exec_q, exec_d;
  logic        phy_rstn_q, phy_rstn_d;
  logic        init_done_q, init_done_d;
  logic        link_up_q, link_up_d;
  logic        error_q, error_d;
  error_code_t err_code_q, err_code_d;
  logic        restart_pend_q, restart_pend_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;

  logic        timer_start;
  logic [31:0] timer_load;
  logic        timer_expired;

  cmd_t        cur_cmd;
  logic        in_cmd;
  logic        restart_any;
  logic        txn_done;
  logic        txn_timeout;
  logic        enter_cmd;
  logic        go_restart;

  mgmt_delay_timer #(
    .RST_VALUE (HOLD_LOAD)
  ) u_timer (
    .clk        (clk),
    .rst_n      (reset_n),
    .start      (timer_start),
    .load_value (timer_load),
    .expired    (timer_expired)
  );

  // Handshakes: a beat moves on a cycle where valid && ready are both high.
  // cmd_valid is held with stable fields until accepted; data_out_ready is
  // high only while a read response is awaited.
  assign cur_cmd        = cmd_for_state(state_q);
  assign in_cmd         = cur_cmd.is_cmd;
  assign cmd_valid      = in_cmd && (exec_q == EX_ISSUE);
  assign data_out_ready = in_cmd && (exec_q == EX_RD_WAIT);
  assign cmd_phy_addr   = in_cmd ? PHY_ADDR : 5'd0;
  assign cmd_reg_addr   = cur_cmd.reg_addr;
  assign cmd_data       = cur_cmd.data;
  assign cmd_opcode     = cur_cmd.opcode;

  assign phy_rstn   = phy_rstn_q;
  assign init_done  = init_done_q;
  assign link_up    = link_up_q;
  assign error      = error_q;
  assign error_code = err_code_q;

  assign restart_any = restart || restart_pend_q;

  always_comb begin
    state_d        = state_q;
    exec_d         = exec_q;
    phy_rstn_d     = phy_rstn_q;
    init_done_d    = init_done_q;
    link_up_d      = link_up_q;
    error_d        = error_q;
    err_code_d     = err_code_q;
    restart_pend_d = restart_pend_q || restart;
    poll_cnt_d     = poll_cnt_q;
    timer_start    = 1'b0;
    timer_load     = TO_LOAD;
    txn_done       = 1'b0;
    txn_timeout    = 1'b0;
    enter_cmd      = 1'b0;
    go_restart     = 1'b0;

    if (in_cmd) begin
      unique case (exec_q)
        EX_ISSUE: begin
          if (cmd_ready) begin
            timer_start = 1'b1;
            exec_d      = (cur_cmd.opcode == MDIO_OP_READ) ? EX_RD_WAIT : EX_WR_SETTLE;
          end else if (timer_expired) begin
            txn_timeout = 1'b1;
          end
        end
        // The master may raise busy up to two clocks after accept.
        EX_WR_SETTLE: begin
          if (timer_expired) txn_timeout = 1'b1;
          else               exec_d      = EX_WR_BUSY;
        end
        EX_WR_BUSY: begin
          if (!busy)              txn_done    = 1'b1;
          else if (timer_expired) txn_timeout = 1'b1;
        end
        EX_RD_WAIT: begin
          if (data_out_valid)     txn_done    = 1'b1;
          else if (timer_expired) txn_timeout = 1'b1;
        end
      endcase
    end

    if (txn_timeout) begin
      if (restart_any) begin
        go_restart = 1'b1;
      end else begin
        state_d     = ST_ERROR;
        exec_d      = EX_ISSUE;
        err_code_d  = ERR_TIMEOUT;
        error_d     = 1'b1;
        init_done_d = 1'b0;
        link_up_d   = 1'b0;
      end
    end else if (txn_done) begin
      if (restart_any) begin
        go_restart = 1'b1;
      end else begin
        case (state_q)
          ST_W_BMCR_RST: begin
            poll_cnt_d = 16'd0;
            state_d    = ST_R_BMCR;
            enter_cmd  = 1'b1;
          end
          ST_R_BMCR: begin
            if ((data_out & BMCR_SOFT_RESET) == 16'h0000) begin
              state_d   = ST_W_ANAR;
              enter_cmd = 1'b1;
            end else if ((poll_cnt_q + 16'd1) >= POLL_LIMIT) begin
              state_d     = ST_ERROR;
              exec_d      = EX_ISSUE;
              err_code_d  = ERR_RESET_STUCK;
              error_d     = 1'b1;
              init_done_d = 1'b0;
              link_up_d   = 1'b0;
            end else begin
              poll_cnt_d = poll_cnt_q + 16'd1;
              enter_cmd  = 1'b1;
            end
          end
          ST_W_ANAR: begin
            state_d   = ST_W_BMCR_AN;
            enter_cmd = 1'b1;
          end
          ST_W_BMCR_AN: begin
            init_done_d = 1'b1;
            state_d     = ST_POLL_GAP;
            exec_d      = EX_ISSUE;
            timer_start = 1'b1;
            timer_load  = POLL_LOAD;
          end
          // BMSR link is latched-low: the first read only clears the latch.
          ST_R_BMSR1: begin
            state_d   = ST_R_BMSR2;
            enter_cmd = 1'b1;
          end
          ST_R_BMSR2: begin
            link_up_d   = (data_out & BMSR_LINK_BIT) != 16'h0000;
            state_d     = ST_POLL_GAP;
            exec_d      = EX_ISSUE;
            timer_start = 1'b1;
            timer_load  = POLL_LOAD;
          end
          default: ;
        endcase
      end
    end else if (!in_cmd) begin
      if (restart_any) begin
        go_restart = 1'b1;
      end else begin
        case (state_q)
          ST_HOLD_RST: begin
            if (timer_expired) begin
              phy_rstn_d  = 1'b1;
              state_d     = ST_PWR_WAIT;
              timer_start = 1'b1;
              timer_load  = PWR_LOAD;
            end
          end
          ST_PWR_WAIT: begin
            if (timer_expired) begin
              state_d   = ST_W_BMCR_RST;
              enter_cmd = 1'b1;
            end
          end
          ST_POLL_GAP: begin
            if (timer_expired) begin
              state_d   = ST_R_BMSR1;
              enter_cmd = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end

    if (enter_cmd) begin
      exec_d      = EX_ISSUE;
      timer_start = 1'b1;
      timer_load  = TO_LOAD;
    end

    if (go_restart) begin
      state_d        = ST_HOLD_RST;
      exec_d         = EX_ISSUE;
      phy_rstn_d     = 1'b0;
      init_done_d    = 1'b0;
      link_up_d      = 1'b0;
      error_d        = 1'b0;
      err_code_d     = ERR_NONE;
      restart_pend_d = 1'b0;
      timer_start    = 1'b1;
      timer_load     = HOLD_LOAD;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_HOLD_RST;
      exec_q         <= EX_ISSUE;
      phy_rstn_q     <= 1'b0;
      init_done_q    <= 1'b0;
      link_up_q      <= 1'b0;
      error_q        <= 1'b0;
      err_code_q     <= ERR_NONE;
      restart_pend_q <= 1'b0;
      poll_cnt_q     <= 16'd0;
    end else begin
      state_q        <= state_d;
      exec_q         <= exec_d;
      phy_rstn_q     <= phy_rstn_d;
      init_done_q    <= init_done_d;
      link_up_q      <= link_up_d;
      error_q        <= error_d;
      err_code_q     <= err_code_d;
      restart_pend_q <= restart_pend_d;
      poll_cnt_q     <= poll_cnt_d;
    end
  end

endmodule

// File: tb/tb_eth_phy_mgmt_sequencer.sv
// Bench for eth_phy_mgmt_sequencer: an MDIO master model answers commands
// with random latencies; expected commands and link state come from a queue model.
module tb_eth_phy_mgmt_sequencer;

  localparam int PHY_RESET_CYCLES    = 4;
  localparam int POWERUP_CYCLES      = 10;
  localparam int POLL_CYCLES         = 20;
  localparam int RESP_TIMEOUT_CYCLES = 50;
  localparam int RESET_POLL_LIMIT    = 16;
  localparam logic [4:0] PHY = 5'd1;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        restart;
  logic        phy_rstn;
  logic [4:0]  cmd_phy_addr;
  logic [4:0]  cmd_reg_addr;
  logic [15:0] cmd_data;
  logic [1:0]  cmd_opcode;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] data_out;
  logic        data_out_valid;
  logic        data_out_ready;
  logic        busy;
  logic        init_done;
  logic        link_up;
  logic        error;
  logic [1:0]  error_code;

  int checks = 0;
  int failures = 0;
  logic [22:0] exp_q[$];
  logic [15:0] rsp_q[$];
  logic        exp_link = 1'b0;

  always #5 clk = ~clk;

  eth_phy_mgmt_sequencer #(
    .PHY_ADDR            (PHY),
    .PHY_RESET_CYCLES    (PHY_RESET_CYCLES),
    .POWERUP_CYCLES      (POWERUP_CYCLES),
    .POLL_CYCLES         (POLL_CYCLES),
    .RESP_TIMEOUT_CYCLES (RESP_TIMEOUT_CYCLES),
    .RESET_POLL_LIMIT    (RESET_POLL_LIMIT)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .restart        (restart),
    .phy_rstn       (phy_rstn),
    .cmd_phy_addr   (cmd_phy_addr),
    .cmd_reg_addr   (cmd_reg_addr),
    .cmd_data       (cmd_data),
    .cmd_opcode     (cmd_opcode),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .busy           (busy),
    .init_done      (init_done),
    .link_up        (link_up),
    .error          (error),
    .error_code     (error_code)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_cmd(input logic [4:0] r, input logic [15:0] d, input logic [1:0] op);
    exp_q.push_back({r, d, op});
  endfunction

  // Master model: waits for a command, checks it, accepts it, then plays
  // busy (writes, raised two clocks after accept) or a read response.
  task automatic serve(input string tag, input int ready_dly, input int busy_len,
                       input int rsp_dly, input int restart_at, output int wait_cyc);
    logic [27:0] fields;
    logic [22:0] exp;
    logic [15:0] obs_data;
    logic [15:0] rd;
    bit          stable;
    bit          quiet;
    bit          rdy_ok;
    int          n;
    wait_cyc = 0;
    while (cmd_valid !== 1'b1 && wait_cyc < 500) begin
      @(negedge clk);
      wait_cyc++;
    end
    check({tag, "_issued"}, {31'd0, cmd_valid}, 32'd1);
    exp = exp_q.pop_front();
    obs_data = (cmd_opcode == OP_RD) ? 16'h0000 : cmd_data;
    check({tag, "_cmd"}, {9'd0, cmd_reg_addr, obs_data, cmd_opcode}, {9'd0, exp});
    check({tag, "_phy"}, {27'd0, cmd_phy_addr}, {27'd0, PHY});
    fields = {cmd_phy_addr, cmd_reg_addr, cmd_data, cmd_opcode};
    stable = 1'b1;
    for (int i = 0; i < ready_dly; i++) begin
      restart = (i == restart_at);
      @(negedge clk);
      if (cmd_valid !== 1'b1 || {cmd_phy_addr, cmd_reg_addr, cmd_data, cmd_opcode} !== fields)
        stable = 1'b0;
    end
    restart = 1'b0;
    if (ready_dly > 0) check({tag, "_stable"}, {31'd0, stable}, 32'd1);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check({tag, "_accept"}, {31'd0, cmd_valid}, 32'd0);
    if (exp[1:0] == OP_WR) begin
      quiet = 1'b1;
      @(negedge clk);
      busy = 1'b1;
      for (int i = 0; i < busy_len; i++) begin
        @(negedge clk);
        if (cmd_valid !== 1'b0) quiet = 1'b0;
      end
      busy = 1'b0;
      check({tag, "_busy_wait"}, {31'd0, quiet}, 32'd1);
    end else if (rsp_dly < 0) begin
      n = 0;
      while (error !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check({tag, "_timeout_cycles"}, n, RESP_TIMEOUT_CYCLES);
    end else begin
      rd = rsp_q.pop_front();
      rdy_ok = 1'b1;
      for (int i = 0; i < rsp_dly; i++) begin
        if (data_out_ready !== 1'b1) rdy_ok = 1'b0;
        @(negedge clk);
      end
      check({tag, "_rd_ready"}, {31'd0, rdy_ok && (data_out_ready === 1'b1)}, 32'd1);
      data_out       = rd;
      data_out_valid = 1'b1;
      @(negedge clk);
      data_out_valid = 1'b0;
      data_out       = 16'(($urandom));
      check({tag, "_rd_release"}, {31'd0, data_out_ready}, 32'd0);
    end
  endtask

  task automatic serve_rnd(input string tag);
    int w;
    serve(tag, $urandom_range(0, 3), $urandom_range(1, 6), $urandom_range(0, 4), -1, w);
  endtask

  // Expected init traffic: soft reset, (busy_reads + 1) BMCR reads, ANAR, AN restart.
  task automatic run_init(input string tag, input int busy_reads, input logic [15:0] final_bmcr);
    push_cmd(5'h00, 16'h8000, OP_WR);
    for (int i = 0; i <= busy_reads; i++) begin
      push_cmd(5'h00, 16'h0000, OP_RD);
      rsp_q.push_back((i == busy_reads) ? final_bmcr : 16'h8000);
    end
    push_cmd(5'h04, 16'h01E1, OP_WR);
    push_cmd(5'h00, 16'h1200, OP_WR);
    serve_rnd({tag, "_wr_rst"});
    for (int i = 0; i <= busy_reads; i++) serve_rnd($sformatf("%s_rd_bmcr%0d", tag, i));
    serve_rnd({tag, "_wr_anar"});
    check({tag, "_init_pending"}, {31'd0, init_done}, 32'd0);
    serve_rnd({tag, "_wr_an"});
    @(negedge clk);
    check({tag, "_init_done"}, {31'd0, init_done}, 32'd1);
    check({tag, "_no_error"}, {31'd0, error}, 32'd0);
  endtask

  task automatic do_poll(input string tag, input logic [15:0] d1, input logic [15:0] d2);
    int gap;
    int w;
    push_cmd(5'h01, 16'h0000, OP_RD);
    push_cmd(5'h01, 16'h0000, OP_RD);
    rsp_q.push_back(d1);
    rsp_q.push_back(d2);
    serve({tag, "_r1"}, $urandom_range(0, 3), 1, $urandom_range(0, 4), -1, gap);
    check({tag, "_gap"}, gap, POLL_CYCLES);
    check({tag, "_discard"}, {31'd0, link_up}, {31'd0, exp_link});
    serve({tag, "_r2"}, $urandom_range(0, 3), 1, $urandom_range(0, 4), -1, w);
    exp_link = d2[2];
    check({tag, "_link"}, {31'd0, link_up}, {31'd0, exp_link});
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (cmd_valid !== 1'b0 || data_out_ready !== 1'b0) ok = 1'b0;
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    exp_link = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int w;
    int k;
    reset_n = 1'b0;
    restart = 1'b0;
    cmd_ready = 1'b0;
    data_out = 16'h0000;
    data_out_valid = 1'b0;
    busy = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_phy_rstn", {31'd0, phy_rstn}, 32'd0);
    check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_rd_ready", {31'd0, data_out_ready}, 32'd0);
    check("rst_flags", {28'd0, init_done, link_up, error, 1'b0}, 32'd0);
    check("rst_error_code", {30'd0, error_code}, 32'd0);
    check("rst_cmd_fields", {4'd0, cmd_phy_addr, cmd_reg_addr, cmd_data, cmd_opcode}, 32'd0);

    // Power-up timing: hold, then power-up wait, then first command.
    reset_n = 1'b1;
    n = 0;
    while (phy_rstn !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hold_cycles", n, PHY_RESET_CYCLES);
    push_cmd(5'h00, 16'h8000, OP_WR);
    serve("first_wr_rst", $urandom_range(0, 3), $urandom_range(1, 6), 0, -1, w);
    check("powerup_cycles", w, POWERUP_CYCLES);
    push_cmd(5'h00, 16'h0000, OP_RD); rsp_q.push_back(16'h8000);
    push_cmd(5'h00, 16'h0000, OP_RD); rsp_q.push_back(16'h8000);
    push_cmd(5'h00, 16'h0000, OP_RD); rsp_q.push_back(16'h1140);
    push_cmd(5'h04, 16'h01E1, OP_WR);
    push_cmd(5'h00, 16'h1200, OP_WR);
    for (int i = 0; i < 3; i++) serve_rnd($sformatf("a_rd_bmcr%0d", i));
    serve_rnd("a_wr_anar");
    check("a_init_pending", {31'd0, init_done}, 32'd0);
    serve_rnd("a_wr_an");
    @(negedge clk);
    check("a_init_done", {31'd0, init_done}, 32'd1);
    check("a_no_error", {31'd0, error}, 32'd0);

    do_poll("poll_up", 16'h7809, 16'h782D);
    do_poll("poll_down", 16'h782D, 16'h7809);
    for (int i = 0; i < 3; i++) do_poll($sformatf("poll_rnd%0d", i), 16'($urandom), 16'($urandom));
    do_poll("poll_last", 16'h0000, 16'h7FFF);

    // Restart while idle in the poll gap, then a read that never answers.
    pulse_restart();
    check("b_restart_rstn", {31'd0, phy_rstn}, 32'd0);
    check("b_restart_flags", {30'd0, init_done, link_up}, 32'd0);
    n = 0;
    while (phy_rstn !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b_hold_cycles", n, PHY_RESET_CYCLES);
    push_cmd(5'h00, 16'h8000, OP_WR);
    push_cmd(5'h00, 16'h0000, OP_RD);
    serve_rnd("b_wr_rst");
    serve("b_rd_noresp", $urandom_range(0, 3), 1, -1, -1, w);
    check("b_err_code", {30'd0, error_code}, 32'd1);
    check("b_err_flag", {31'd0, error}, 32'd1);
    check("b_err_init", {31'd0, init_done}, 32'd0);
    check("b_err_rstn_kept", {31'd0, phy_rstn}, 32'd1);
    check_quiet("b_err_quiet", 30);

    // Restart out of ERROR; soft reset never clears.
    pulse_restart();
    check("c_err_cleared", {29'd0, error, error_code}, 32'd0);
    push_cmd(5'h00, 16'h8000, OP_WR);
    for (int i = 0; i < RESET_POLL_LIMIT; i++) begin
      push_cmd(5'h00, 16'h0000, OP_RD);
      rsp_q.push_back(16'h8000);
    end
    serve_rnd("c_wr_rst");
    for (int i = 0; i < RESET_POLL_LIMIT; i++) serve_rnd($sformatf("c_rd_bmcr%0d", i));
    check("c_err_code", {30'd0, error_code}, 32'd2);
    check("c_err_flag", {31'd0, error}, 32'd1);
    check("c_err_init", {31'd0, init_done}, 32'd0);
    check_quiet("c_no_extra_read", 30);

    // Restart pulsed while a write is stalled: write finishes, then rerun.
    pulse_restart();
    push_cmd(5'h00, 16'h8000, OP_WR);
    serve("d_wr_stalled", 5, $urandom_range(1, 6), 0, 1, w);
    check("d_restart_deferred", {31'd0, phy_rstn}, 32'd1);
    n = 0;
    while (phy_rstn !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("d_restart_after_txn", n, 1);
    check("d_no_cmd_after", {31'd0, cmd_valid}, 32'd0);
    k = $urandom_range(0, 3);
    run_init("d", k, 16'($urandom) & 16'h7FFF);
    do_poll("d_poll", 16'($urandom), 16'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
